nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Wide adder built from one 4-bit carry-lookahead slice, time-shared one nibble per cycle.
//  Accepts WIDTH-bit operands over a valid/ready handshake.
//  Walks nibbles LSB-first through the slice, registering carry between nibbles.
//  Presents the assembled sum and carry-out downstream; trades latency for area.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 8
//  NIB    WIDTH/4 (localparam)  nibbles per operation; counter width = $clog2(NIB)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in to nibble 0
//  out_valid  out  1      sum/co valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a + b + ci, modulo 2^WIDTH
//  co         out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, sum=0, co=0, nibble count=0, carry reg=0.
//  Reset asserted mid-operation aborts it; no partial result is ever presented.
//  FSM states:
//   IDLE: in_ready=1. On in_valid: latch a, b, ci; count=0; go to RUN.
//   RUN: in_ready=0. Each cycle, slice adds a[4k+:4] + b[4k+:4] + carry, k=count.
//    Slice sum goes to sum[4k+:4]; carry reg takes slice co; count increments.
//    k=NIB-1: co <= slice co; go to DONE.
//   DONE: out_valid=1, in_ready=0; sum/co held stable. On out_ready: go to IDLE, out_valid=0.
//  Latency: out_valid rises NIB+1 edges after the accepting edge. Max rate: 1 op / (NIB+2) cycles.
//  Handshake: transfer occurs only when valid&&ready at a rising edge.
//   in_valid and the a/b/ci values are ignored outside IDLE.
//   out_valid, once high, stays high with stable data until out_ready is sampled high.
//  sum is cleared to 0 at acceptance.
//   sum and co are only meaningful while out_valid=1; they are held until the next acceptance.
//  Carry-in for nibble 0 is the latched ci; no combinational path from inputs to outputs.
//  Wrap: the carry out of the top nibble goes to co only; it is never fed back.
// CONFIGURATION
//  NIBBLE_SERIAL_ADDER_SUB_EN defined:
//   - Adds input port sub (1 bit), latched with the operands.
//   - sub=1 latches ~b as operand B and forces carry-in to 1: sum = a - b, co=1 means no borrow.
//   - Adds output port ovf (1 bit), signed overflow of the top nibble.
//   - ovf resets to 0 and is valid with out_valid.
//  NIBBLE_SERIAL_ADDER_SUB_EN undefined: add-only; no sub or ovf ports.
// STRUCTURE
//  Shared package nsa_pkg:
//   - state enum {IDLE, RUN, DONE}
//   - localparam NIBBLE_W = 4
//   - function nib_count(width) returning width/NIBBLE_W
//  One sub-module, cla4_slice: combinational 4-bit carry-lookahead adder.
//   - Ports: a[3:0], b[3:0], cin -> s[3:0], cout.
//   - Carry terms: generate g = a&b, propagate p = a|b per bit.
//  Top holds the operand regs, carry reg, nibble counter, sum reg and FSM.
// TESTING (WIDTH=16, NIB=4)
//  - 0x1234 + 0x4321, ci=0 -> sum=0x5555, co=0; out_valid exactly 5 edges after accept.
//  - 0xFFFF + 0x0001, ci=0 -> sum=0x0000, co=1 (carry ripples through all 4 nibbles).
//  - 0x0000 + 0x0000, ci=1 -> sum=0x0001, co=0.
//  - Backpressure: out_ready held 0 for 6 cycles after out_valid.
//    -> sum/co/out_valid stable, in_ready=0, a new in_valid is not accepted.
//  - Assert rst during RUN at count=2 -> next cycle in_ready=1, out_valid=0, sum=0, co=0.
//    A later 0x0001+0x0001 then yields 0x0002.
//  - SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, co=0, ovf=0.
//    a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, co=1, ovf=1.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned NIBBLE_W = 4;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a | b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = a ^ b ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder time-sharing one 4-bit CLA slice, one nibble per cycle, LSB first.
// Optional subtract mode and overflow flag under NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             co
);

    localparam int unsigned NIB = nib_count(WIDTH);
    localparam int unsigned CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    sum_reg;
    logic                carry;
    logic                co_reg;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    b_in;
    logic                c_in;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic ovf_reg;

    // Subtraction is a + ~b + 1, so the inversion happens once at latch time.
    always_comb begin
        b_in = sub ? ~b : b;
        c_in = sub | ci;
    end
`else
    always_comb begin
        b_in = b;
        c_in = ci;
    end
`endif

    always_comb begin
        nib_a = a_reg[NIBBLE_W*int'(cnt) +: NIBBLE_W];
        nib_b = b_reg[NIBBLE_W*int'(cnt) +: NIBBLE_W];
    end

    cla4_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            co_reg  <= 1'b0;
            cnt     <= '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            ovf_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b_in;
                        carry   <= c_in;
                        cnt     <= '0;
                        sum_reg <= '0;
                    end
                end
                RUN: begin
                    sum_reg[NIBBLE_W*int'(cnt) +: NIBBLE_W] <= slice_s;
                    carry <= slice_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        co_reg <= slice_co;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                        // Same-sign operands producing a different-sign result.
                        ovf_reg <= (nib_a[NIBBLE_W-1] == nib_b[NIBBLE_W-1]) &&
                                   (slice_s[NIBBLE_W-1] != nib_a[NIBBLE_W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sum = sum_reg;
        co  = co_reg;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        ovf = ovf_reg;
`endif
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) against an arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         sub;
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .co        (co)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, co, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic civ, input logic subv);
        int          sa;
        int          sb;
        int          sr;
        int unsigned full;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (subv) begin
            full = (int'(av) - int'(bv)) & 32'hFFFF;
            s    = full[W-1:0];
            c    = (av >= bv);
            sr   = sa - sb;
        end else begin
            full = int'(av) + int'(bv) + int'(civ);
            s    = full[W-1:0];
            c    = full[W];
            sr   = sa + sb + int'(civ);
        end
        v = (sr > 32767) || (sr < -32768);
        return {v, c, s};
    endfunction

    task automatic drive_sub(input logic subv);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub = subv;
`else
        if (subv) $error("FAIL drive_sub: observed=1 expected=0");
`endif
    endtask

    // Accept one operation and wait (bounded) for out_valid; the accepting edge counts as edge 1.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic civ, input logic subv);
        int n;
        a = av;
        b = bv;
        ci = civ;
        drive_sub(subv);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        ci = 1'($urandom);
        check("busy_after_accept", 32'(in_ready), 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("latency", n, 4);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic civ, input logic subv);
        logic [W+1:0] exp;
        exp = model(av, bv, civ, subv);
        check({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, "_co"}, 32'(co), 32'(exp[W]));
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp[W+1]));
`endif
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_dropped", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic civ, input logic subv);
        start_op(av, bv, civ, subv);
        check_result(tag, av, bv, civ, subv);
        finish_op();
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic         held_co;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        ci = 1'b0;
        drive_sub(1'b0);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        do_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result must hold and new operands must be refused.
        start_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
        held_sum = sum;
        held_co  = co;
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'(held_sum));
            check("bp_co", 32'(co), 32'(held_co));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check_result("bp_result", 16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
        finish_op();
        step();
        check("bp_not_accepted", 32'(out_valid), 32'd0);

        // Reset while the third nibble is about to be processed.
        a = 16'hFFFF;
        b = 16'hFFFF;
        ci = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_co", 32'(co), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("abort_still_idle", 32'(out_valid), 32'd0);
        do_op("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            start_op(ra, rb, rc, rs);
            repeat ($urandom_range(0, 3)) step();
            check_result("rand", ra, rb, rc, rs);
            finish_op();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
